// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the bus datapath.
// Strobes are decoded combinationally from the step state and the opcode held in IR.
module control_unit #(
  parameter int BITS = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] IRVal,
  input  logic            stop,
  output logic            CONin,
  output logic            PCin,
  output logic            IRin,
  output logic            RYin,
  output logic            RZin,
  output logic            MARin,
  output logic            HILOin,
  output logic            OUTPUTin,
  output logic            INTERin,
  output logic            MDRin,
  output logic            Read,
  output logic            Write,
  output logic            INPUTout,
  output logic            MDRout,
  output logic            HILOout,
  output logic            RZout,
  output logic            PCout,
  output logic            Cout,
  output logic            INTERout,
  output logic            BAout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rout,
  output logic            Rin,
  output logic            ADD,
  output logic            SUB,
  output logic            MUL,
  output logic            DIV,
  output logic            SHR,
  output logic            SHL,
  output logic            ROR,
  output logic            ROL,
  output logic            AND,
  output logic            OR,
  output logic            NEGATE,
  output logic            NOT,
  output logic            IncPC,
  output logic            run,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_LD   = 4'd0,
    C_LDI  = 4'd1,
    C_ST   = 4'd2,
    C_ALU  = 4'd3,
    C_IMM  = 4'd4,
    C_MD   = 4'd5,
    C_UN   = 4'd6,
    C_NOP  = 4'd7,
    C_HLT  = 4'd8,
    C_BAD  = 4'd9
  } op_class_t;

  // ALU select vector order: {ADD SUB MUL DIV SHR SHL ROR ROL AND OR NEGATE NOT}
  localparam logic [11:0] ALU_ADD = 12'b1000_0000_0000;
  localparam logic [11:0] ALU_SUB = 12'b0100_0000_0000;
  localparam logic [11:0] ALU_MUL = 12'b0010_0000_0000;
  localparam logic [11:0] ALU_DIV = 12'b0001_0000_0000;
  localparam logic [11:0] ALU_SHR = 12'b0000_1000_0000;
  localparam logic [11:0] ALU_SHL = 12'b0000_0100_0000;
  localparam logic [11:0] ALU_ROR = 12'b0000_0010_0000;
  localparam logic [11:0] ALU_ROL = 12'b0000_0001_0000;
  localparam logic [11:0] ALU_AND = 12'b0000_0000_1000;
  localparam logic [11:0] ALU_OR  = 12'b0000_0000_0100;
  localparam logic [11:0] ALU_NEG = 12'b0000_0000_0010;
  localparam logic [11:0] ALU_NOT = 12'b0000_0000_0001;

  function automatic op_class_t classify(input logic [OPW-1:0] op);
    case (op)
      5'd0:                                  classify = C_LD;
      5'd1:                                  classify = C_LDI;
      5'd2:                                  classify = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6,
      5'd7, 5'd8, 5'd9, 5'd10:               classify = C_ALU;
      5'd11, 5'd12, 5'd13:                   classify = C_IMM;
      5'd14, 5'd15:                          classify = C_MD;
      5'd16, 5'd17:                          classify = C_UN;
      5'd26:                                 classify = C_NOP;
      5'd27:                                 classify = C_HLT;
      default:                               classify = C_BAD;
    endcase
  endfunction

  function automatic logic [11:0] alu_sel(input logic [OPW-1:0] op);
    case (op)
      5'd3, 5'd11: alu_sel = ALU_ADD;
      5'd4:        alu_sel = ALU_SUB;
      5'd5, 5'd12: alu_sel = ALU_AND;
      5'd6, 5'd13: alu_sel = ALU_OR;
      5'd7:        alu_sel = ALU_SHR;
      5'd8:        alu_sel = ALU_SHL;
      5'd9:        alu_sel = ALU_ROR;
      5'd10:       alu_sel = ALU_ROL;
      5'd14:       alu_sel = ALU_MUL;
      5'd15:       alu_sel = ALU_DIV;
      5'd16:       alu_sel = ALU_NEG;
      5'd17:       alu_sel = ALU_NOT;
      default:     alu_sel = 12'd0;
    endcase
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic            illegal_r;
  logic            set_illegal_s;
  logic [OPW-1:0]  op_s;
  op_class_t       cls_s;
  logic [11:0]     alu_vec_s;
  logic            unused_ir_s;

  assign op_s        = IRVal[BITS-1 -: OPW];
  assign cls_s       = classify(op_s);
  assign unused_ir_s = ^IRVal[BITS-OPW-1:0];
  assign illegal     = illegal_r;
  assign {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT} = alu_vec_s;

  // State register and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_RST;
      illegal_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (set_illegal_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Step decode: next state plus every datapath strobe for the current step.
  always_comb begin
    next_state_s  = state_r;
    set_illegal_s = 1'b0;
    alu_vec_s     = 12'd0;
    CONin    = 1'b0;  PCin     = 1'b0;  IRin    = 1'b0;  RYin   = 1'b0;
    RZin     = 1'b0;  MARin    = 1'b0;  HILOin  = 1'b0;  OUTPUTin = 1'b0;
    INTERin  = 1'b0;  MDRin    = 1'b0;  Read    = 1'b0;  Write  = 1'b0;
    INPUTout = 1'b0;  MDRout   = 1'b0;  HILOout = 1'b0;  RZout  = 1'b0;
    PCout    = 1'b0;  Cout     = 1'b0;  INTERout = 1'b0; BAout  = 1'b0;
    Gra      = 1'b0;  Grb      = 1'b0;  Grc     = 1'b0;  Rout   = 1'b0;
    Rin      = 1'b0;  IncPC    = 1'b0;

    case (state_r)
      S_RST: next_state_s = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
        next_state_s = S_T1;
      end
      S_T1: begin
        RZout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next_state_s = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state_s = S_T3;
      end
      S_T3: begin
        case (cls_s)
          C_LD, C_LDI, C_ST: begin
            Grb = 1'b1; BAout = 1'b1; RYin = 1'b1;
            next_state_s = S_T4;
          end
          C_ALU, C_IMM: begin
            Grb = 1'b1; Rout = 1'b1; RYin = 1'b1;
            next_state_s = S_T4;
          end
          C_MD: begin
            Gra = 1'b1; Rout = 1'b1; RYin = 1'b1;
            next_state_s = S_T4;
          end
          C_UN: begin
            Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; alu_vec_s = alu_sel(op_s);
            next_state_s = S_T4;
          end
          C_NOP:   next_state_s = stop ? S_HALT : S_T0;
          C_HLT:   next_state_s = S_HALT;
          default: begin
            // Undefined opcode: no strobes, latch the error and park.
            set_illegal_s = 1'b1;
            next_state_s  = S_HALT;
          end
        endcase
      end
      S_T4: begin
        case (cls_s)
          C_LD, C_LDI, C_ST: begin
            Cout = 1'b1; RZin = 1'b1; alu_vec_s = ALU_ADD;
            next_state_s = S_T5;
          end
          C_ALU: begin
            Grc = 1'b1; Rout = 1'b1; RZin = 1'b1; alu_vec_s = alu_sel(op_s);
            next_state_s = S_T5;
          end
          C_IMM: begin
            Cout = 1'b1; RZin = 1'b1; alu_vec_s = alu_sel(op_s);
            next_state_s = S_T5;
          end
          C_MD: begin
            Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; alu_vec_s = alu_sel(op_s);
            next_state_s = S_T5;
          end
          C_UN: begin
            RZout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state_s = stop ? S_HALT : S_T0;
          end
          default: next_state_s = S_HALT;
        endcase
      end
      S_T5: begin
        case (cls_s)
          C_LD, C_ST: begin
            RZout = 1'b1; MARin = 1'b1;
            next_state_s = S_T6;
          end
          C_LDI, C_ALU, C_IMM: begin
            RZout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state_s = stop ? S_HALT : S_T0;
          end
          C_MD: begin
            RZout = 1'b1; HILOin = 1'b1;
            next_state_s = stop ? S_HALT : S_T0;
          end
          default: next_state_s = S_HALT;
        endcase
      end
      S_T6: begin
        case (cls_s)
          C_LD: begin
            Read = 1'b1; MDRin = 1'b1;
            next_state_s = S_T7;
          end
          C_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            next_state_s = S_T7;
          end
          default: next_state_s = S_HALT;
        endcase
      end
      S_T7: begin
        case (cls_s)
          C_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state_s = stop ? S_HALT : S_T0;
          end
          C_ST: begin
            Write = 1'b1;
            next_state_s = stop ? S_HALT : S_T0;
          end
          default: next_state_s = S_HALT;
        endcase
      end
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_RST;
    endcase

    if ((state_r == S_RST) || (state_r == S_HALT)) begin
      run = 1'b0;
    end else begin
      run = 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors for each instruction class,
// stop handling, halt/illegal opcodes and mid-instruction reset.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stop;
  logic [31:0] IRVal;
  logic CONin, PCin, IRin, RYin, RZin, MARin, HILOin, OUTPUTin, INTERin, MDRin;
  logic Read, Write;
  logic INPUTout, MDRout, HILOout, RZout, PCout, Cout, INTERout, BAout;
  logic Gra, Grb, Grc, Rout, Rin;
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
  logic run, illegal;

  int total = 0;
  int bad   = 0;

  logic [37:0] strb;
  assign strb = {CONin, PCin, IRin, RYin, RZin, MARin, HILOin, OUTPUTin, INTERin, MDRin,
                 Read, Write, INPUTout, MDRout, HILOout, RZout, PCout, Cout, INTERout, BAout,
                 Gra, Grb, Grc, Rout, Rin,
                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC};

  localparam logic [37:0] M_INCPC  = 38'd1 << 0;
  localparam logic [37:0] M_NOT    = 38'd1 << 1;
  localparam logic [37:0] M_NEG    = 38'd1 << 2;
  localparam logic [37:0] M_OR     = 38'd1 << 3;
  localparam logic [37:0] M_AND    = 38'd1 << 4;
  localparam logic [37:0] M_ROL    = 38'd1 << 5;
  localparam logic [37:0] M_ROR    = 38'd1 << 6;
  localparam logic [37:0] M_SHL    = 38'd1 << 7;
  localparam logic [37:0] M_SHR    = 38'd1 << 8;
  localparam logic [37:0] M_DIV    = 38'd1 << 9;
  localparam logic [37:0] M_MUL    = 38'd1 << 10;
  localparam logic [37:0] M_SUB    = 38'd1 << 11;
  localparam logic [37:0] M_ADD    = 38'd1 << 12;
  localparam logic [37:0] M_RIN    = 38'd1 << 13;
  localparam logic [37:0] M_ROUT   = 38'd1 << 14;
  localparam logic [37:0] M_GRC    = 38'd1 << 15;
  localparam logic [37:0] M_GRB    = 38'd1 << 16;
  localparam logic [37:0] M_GRA    = 38'd1 << 17;
  localparam logic [37:0] M_BAOUT  = 38'd1 << 18;
  localparam logic [37:0] M_COUT   = 38'd1 << 20;
  localparam logic [37:0] M_PCOUT  = 38'd1 << 21;
  localparam logic [37:0] M_RZOUT  = 38'd1 << 22;
  localparam logic [37:0] M_MDROUT = 38'd1 << 24;
  localparam logic [37:0] M_WRITE  = 38'd1 << 26;
  localparam logic [37:0] M_READ   = 38'd1 << 27;
  localparam logic [37:0] M_MDRIN  = 38'd1 << 28;
  localparam logic [37:0] M_HILOIN = 38'd1 << 31;
  localparam logic [37:0] M_MARIN  = 38'd1 << 32;
  localparam logic [37:0] M_RZIN   = 38'd1 << 33;
  localparam logic [37:0] M_RYIN   = 38'd1 << 34;
  localparam logic [37:0] M_IRIN   = 38'd1 << 35;
  localparam logic [37:0] M_PCIN   = 38'd1 << 36;

  localparam logic [37:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_RZIN;
  localparam logic [37:0] W_T1 = M_RZOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [37:0] W_T2 = M_MDROUT | M_IRIN;
  localparam logic [37:0] W_WB = M_RZOUT | M_GRA | M_RIN;

  control_unit #(.BITS(32), .OPW(5)) dut (
    .clk(clk), .reset(reset), .IRVal(IRVal), .stop(stop),
    .CONin(CONin), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
    .HILOin(HILOin), .OUTPUTin(OUTPUTin), .INTERin(INTERin), .MDRin(MDRin),
    .Read(Read), .Write(Write),
    .INPUTout(INPUTout), .MDRout(MDRout), .HILOout(HILOout), .RZout(RZout), .PCout(PCout),
    .Cout(Cout), .INTERout(INTERout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .Rin(Rin),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT), .IncPC(IncPC),
    .run(run), .illegal(illegal)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({strb, run, illegal} !== 40'd0) begin
      bad++;
      $display("FAIL reset: got strb=%h run=%b ill=%b want all 0", strb, run, illegal);
    end
    reset = 1'b0;
  endtask

  task automatic test_ld();
    logic [37:0] e [8];
    e = '{W_T0, W_T1, W_T2, M_GRB | M_BAOUT | M_RYIN, M_COUT | M_ADD | M_RZIN,
          M_RZOUT | M_MARIN, M_READ | M_MDRIN, M_MDROUT | M_GRA | M_RIN};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL ld T%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                 i, strb, run, illegal, e[i]);
      end
      if (i == 2) IRVal = 32'h0080_0065;
    end
  endtask

  task automatic test_st();
    logic [37:0] e [8];
    e = '{W_T0, W_T1, W_T2, M_GRB | M_BAOUT | M_RYIN, M_COUT | M_ADD | M_RZIN,
          M_RZOUT | M_MARIN, M_GRA | M_ROUT | M_MDRIN, M_WRITE};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL st T%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                 i, strb, run, illegal, e[i]);
      end
      if (i == 2) IRVal = 32'h1208_0090;
    end
  endtask

  task automatic test_add_mul();
    logic [37:0] e [6];
    logic [31:0] ir;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ir = 32'h1A92_0000;
        e = '{W_T0, W_T1, W_T2, M_GRB | M_ROUT | M_RYIN, M_GRC | M_ROUT | M_ADD | M_RZIN, W_WB};
      end else begin
        ir = 32'h71A0_0000;
        e = '{W_T0, W_T1, W_T2, M_GRA | M_ROUT | M_RYIN, M_GRB | M_ROUT | M_MUL | M_RZIN,
              M_RZOUT | M_HILOIN};
      end
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        total++;
        if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL add_mul ir=%h T%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                   ir, i, strb, run, illegal, e[i]);
        end
        if (i == 2) IRVal = ir;
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ops  [10];
    logic [37:0] sel  [10];
    logic [37:0] e    [6];
    ops = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
    sel = '{M_SUB, M_AND, M_OR, M_SHR, M_SHL, M_ROR, M_ROL, M_ADD, M_AND, M_OR};
    for (int k = 0; k < 10; k++) begin
      e[0] = W_T0; e[1] = W_T1; e[2] = W_T2;
      e[3] = M_GRB | M_ROUT | M_RYIN;
      e[4] = (k < 7) ? (M_GRC | M_ROUT | sel[k] | M_RZIN) : (M_COUT | sel[k] | M_RZIN);
      e[5] = W_WB;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        total++;
        if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL alu op=%0d T%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                   ops[k], i, strb, run, illegal, e[i]);
        end
        if (i == 2) IRVal = {ops[k], 27'h0123456};
      end
    end
  endtask

  task automatic test_unary_div();
    logic [4:0]  ops [3];
    logic [37:0] e   [3][6];
    int          n   [3];
    ops = '{5'd16, 5'd17, 5'd15};
    n   = '{5, 5, 6};
    e[0] = '{W_T0, W_T1, W_T2, M_GRB | M_ROUT | M_NEG | M_RZIN, W_WB, 38'd0};
    e[1] = '{W_T0, W_T1, W_T2, M_GRB | M_ROUT | M_NOT | M_RZIN, W_WB, 38'd0};
    e[2] = '{W_T0, W_T1, W_T2, M_GRA | M_ROUT | M_RYIN, M_GRB | M_ROUT | M_DIV | M_RZIN,
             M_RZOUT | M_HILOIN};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < n[k]; i++) begin
        @(negedge clk);
        total++;
        if ({strb, run, illegal} !== {e[k][i], 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL unary_div op=%0d T%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                   ops[k], i, strb, run, illegal, e[k][i]);
        end
        if (i == 2) IRVal = {ops[k], 27'h0};
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] e [10];
    e = '{W_T0, W_T1, W_T2, 38'd0,
          W_T0, W_T1, W_T2, M_GRB | M_BAOUT | M_RYIN, M_COUT | M_ADD | M_RZIN, W_WB};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL nop_ldi step%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                 i, strb, run, illegal, e[i]);
      end
      if (i == 2) IRVal = {5'd26, 27'h0};
      if (i == 6) IRVal = {5'd1, 27'h0000100};
    end
  endtask

  task automatic test_stop();
    logic [37:0] e [12];
    e = '{W_T0, W_T1, W_T2, M_GRB | M_BAOUT | M_RYIN, M_COUT | M_ADD | M_RZIN, W_WB,
          W_T0, W_T1, W_T2, M_GRB | M_ROUT | M_RYIN, M_GRC | M_ROUT | M_ADD | M_RZIN, W_WB};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL stop step%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                 i, strb, run, illegal, e[i]);
      end
      if (i == 0)  stop = 1'b1;
      if (i == 2)  begin stop = 1'b0; IRVal = {5'd1, 27'h0}; end
      if (i == 8)  IRVal = 32'h1A92_0000;
      if (i == 10) stop = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== 40'd0) begin
        bad++;
        $display("FAIL stop halt%0d: got strb=%h run=%b ill=%b want all 0", i, strb, run, illegal);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_halt_illegal();
    logic [4:0] ops [4];
    logic       ill;
    ops = '{5'd27, 5'd31, 5'd18, 5'd28};
    for (int k = 0; k < 4; k++) begin
      ill = (k != 0);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== 40'd0) begin
        bad++;
        $display("FAIL halt_ill op=%0d reset: got strb=%h run=%b ill=%b want all 0",
                 ops[k], strb, run, illegal);
      end
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        total++;
        if (i < 4) begin
          if ({strb, run, illegal} !== {((i == 0) ? W_T0 : (i == 1) ? W_T1 : (i == 2) ? W_T2 : 38'd0),
                                        1'b1, 1'b0}) begin
            bad++;
            $display("FAIL halt_ill op=%0d T%0d: got strb=%h run=%b ill=%b", ops[k], i, strb, run, illegal);
          end
        end else begin
          if ({strb, run, illegal} !== {38'd0, 1'b0, ill}) begin
            bad++;
            $display("FAIL halt_ill op=%0d halt%0d: got strb=%h run=%b ill=%b want strb=0 run=0 ill=%b",
                     ops[k], i, strb, run, illegal, ill);
          end
        end
        if (i == 2) IRVal = {ops[k], 27'h0};
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [37:0] e [6];
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({strb, run, illegal} !== 40'd0) begin
      bad++;
      $display("FAIL reset_mid clear: got strb=%h run=%b ill=%b want all 0", strb, run, illegal);
    end
    reset = 1'b0;
    e = '{W_T0, W_T1, W_T2, M_GRB | M_BAOUT | M_RYIN, M_COUT | M_ADD | M_RZIN, M_RZOUT | M_MARIN};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== {e[i], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_mid T%0d: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
                 i, strb, run, illegal, e[i]);
      end
      if (i == 2) IRVal = 32'h0080_0065;
      if (i == 5) reset = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({strb, run, illegal} !== 40'd0) begin
        bad++;
        $display("FAIL reset_mid rst%0d: got strb=%h run=%b ill=%b want all 0", i, strb, run, illegal);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({strb, run, illegal} !== {W_T0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid restart: got strb=%h run=%b ill=%b want strb=%h run=1 ill=0",
               strb, run, illegal, W_T0);
    end
  endtask

  initial begin
    reset = 1'b1;
    stop  = 1'b0;
    IRVal = 32'h0;
    test_reset();
    test_ld();
    test_st();
    test_add_mul();
    test_alu_ops();
    test_unary_div();
    test_back_to_back();
    test_stop();
    test_halt_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
